// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO succeeds only
// when a pop frees an entry in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a show-ahead byte FIFO,
// plus framing-error and overrun pulses.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    output logic [7:0]                    data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CPB = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int TW  = $clog2(CPB);
    localparam logic [TW-1:0] HALF = TW'(CPB / 2);
    localparam logic [TW-1:0] LAST = TW'(CPB - 1);

    rx_state_t     state;
    logic          sync1;
    logic          rx_line;
    logic          rx_prev;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push_req;
    logic          full;
    logic          empty;
    logic          mid;

    assign mid            = (timer == HALF);
    assign data_out_valid = ~empty;

    // Synchronizer resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            rx_line <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= serial_in;
            rx_line <= sync1;
            rx_prev <= rx_line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= '0;
        else if (state == IDLE || state == WAIT_IDLE)
            timer <= '0;
        else
            timer <= (timer == LAST) ? '0 : timer + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shift     <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_prev && !rx_line)
                        state <= START;
                end
                START: begin
                    if (mid) begin
                        state   <= rx_line ? IDLE : DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift   <= {rx_line, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (mid) begin
                        if (rx_line) begin
                            push_req <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_line)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // shift is stable until the next frame reaches DATA, so it can feed the push directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else
            overrun <= push_req & full & ~(data_out_ready & data_out_valid);
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (shift),
        .pop       (data_out_ready),
        .head      (data_out),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 50 clocks per bit and an 8-entry FIFO.
module tb_uart_rx_fifo;

    localparam int CPB = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       frame_err;
    logic       overrun;
    logic [3:0] fifo_count;

    int checks   = 0;
    int failures = 0;
    int fe_seen  = 0;
    int ovr_seen = 0;

    uart_rx_fifo #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (1_000_000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .frame_err      (frame_err),
        .overrun        (overrun),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen++;
        if (overrun === 1'b1) ovr_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; drives start, 8 data bits LSB first, then the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = stop_bit;
        repeat (CPB) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic pop_one;
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
    endtask

    logic       got;
    logic [7:0] got_data;
    int         fe0;
    int         ovr0;
    logic [7:0] exp5 [8];

    initial begin
        rst            = 1'b1;
        serial_in      = 1'b1;
        data_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(data_out_valid), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        repeat (10) @(negedge clk);

        // 1: single byte with consumer always ready
        data_out_ready = 1'b1;
        got = 1'b0;
        got_data = 8'h00;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 10 * CPB + 4; i++) begin
                    @(negedge clk);
                    if (data_out_valid && !got) begin
                        got = 1'b1;
                        got_data = data_out;
                    end
                end
            end
        join
        data_out_ready = 1'b0;
        check("t1_valid_seen", 32'(got), 32'h1);
        check("t1_data", 32'(got_data), 32'hA5);
        check("t1_ferr_count", 32'(fe_seen), 32'h0);
        check("t1_ovr_count", 32'(ovr_seen), 32'h0);
        check("t1_count", 32'(fifo_count), 32'h0);
        repeat (20) @(negedge clk);

        // 2: short low glitch is rejected, then a real frame
        serial_in = 1'b0;
        repeat (10) @(negedge clk);
        serial_in = 1'b1;
        repeat (100) @(negedge clk);
        check("t2_glitch_count", 32'(fifo_count), 32'h0);
        check("t2_glitch_ferr", 32'(fe_seen), 32'h0);
        send_byte(8'h5A, 1'b1);
        check("t2_count", 32'(fifo_count), 32'h1);
        check("t2_data", 32'(data_out), 32'h5A);
        pop_one();
        check("t2_after_pop", 32'(fifo_count), 32'h0);

        // 3: stop bit low gives a framing error, recovery afterwards
        fe0 = fe_seen;
        send_byte(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        check("t3_ferr_pulses", 32'(fe_seen - fe0), 32'h1);
        check("t3_count", 32'(fifo_count), 32'h0);
        send_byte(8'h11, 1'b1);
        check("t3_count2", 32'(fifo_count), 32'h1);
        check("t3_data", 32'(data_out), 32'h11);
        pop_one();

        // 4: nine back-to-back bytes into an 8-entry FIFO with no consumer
        ovr0 = ovr_seen;
        for (int i = 0; i < 9; i++)
            send_byte(8'(i), 1'b1);
        check("t4_count_full", 32'(fifo_count), 32'h8);
        check("t4_ovr_pulses", 32'(ovr_seen - ovr0), 32'h1);
        data_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_pop%0d", i), 32'(data_out), 32'(i));
            @(negedge clk);
        end
        data_out_ready = 1'b0;
        check("t4_empty", 32'(data_out_valid), 32'h0);

        // 5: push into a full FIFO in the same cycle as a pop
        for (int i = 0; i < 8; i++)
            send_byte(8'(8'h10 + i), 1'b1);
        check("t5_full", 32'(fifo_count), 32'h8);
        ovr0 = ovr_seen;
        fork
            send_byte(8'h77, 1'b1);
            begin
                repeat (10 * CPB - 21) @(posedge clk);
                @(negedge clk);
                data_out_ready = 1'b1;
                @(negedge clk);
                data_out_ready = 1'b0;
            end
        join
        check("t5_no_ovr", 32'(ovr_seen - ovr0), 32'h0);
        check("t5_still_full", 32'(fifo_count), 32'h8);
        for (int i = 0; i < 7; i++)
            exp5[i] = 8'(8'h11 + i);
        exp5[7] = 8'h77;
        data_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_pop%0d", i), 32'(data_out), 32'(exp5[i]));
            @(negedge clk);
        end
        data_out_ready = 1'b0;
        check("t5_empty", 32'(fifo_count), 32'h0);

        // 6: reset in the middle of a frame
        fe0 = fe_seen;
        ovr0 = ovr_seen;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (5 * CPB + 20) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check("t6_rst_data", 32'(data_out), 32'h0);
                check("t6_rst_valid", 32'(data_out_valid), 32'h0);
                check("t6_rst_count", 32'(fifo_count), 32'h0);
            end
        join
        repeat (20) @(negedge clk);
        check("t6_no_byte", 32'(fifo_count), 32'h0);
        check("t6_no_pulses", 32'((fe_seen - fe0) + (ovr_seen - ovr0)), 32'h0);
        send_byte(8'hC3, 1'b1);
        check("t6_count", 32'(fifo_count), 32'h1);
        check("t6_data", 32'(data_out), 32'hC3);
        pop_one();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
